// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : game_pkg
//  Purpose  : Shared direction encoding, FSM state codes and helpers for the
//             arrow and player logic.
//  Revision : 1.0  initial release
// ============================================================================
package game_pkg;

    typedef enum logic [1:0] {
        DIR_TOP    = 2'b00,
        DIR_BOTTOM = 2'b01,
        DIR_LEFT   = 2'b10,
        DIR_RIGHT  = 2'b11
    } dir_t;

    typedef logic [2:0] state_t;

    localparam state_t c_st_idle    = 3'd0;
    localparam state_t c_st_gap     = 3'd1;
    localparam state_t c_st_flight  = 3'd2;
    localparam state_t c_st_resolve = 3'd3;
    localparam state_t c_st_over    = 3'd4;

    localparam logic [15:0] c_lfsr_seed = 16'hACE1;

    // An inversed arrow must be blocked on the opposite side of its axis.
    function automatic dir_t required_side(input dir_t dir, input logic inv);
        return inv ? dir_t'(dir ^ 2'b01) : dir;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr16
//  Purpose  : Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11).
//  Revision : 1.0  initial release
// ============================================================================
module lfsr16
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    logic w_feedback;

    assign w_feedback = q[15] ^ q[13] ^ q[12] ^ q[10];

    // The all-zero lock-up state is unreachable from the seed; reload guards it anyway.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= c_lfsr_seed;
        end else if (q == 16'h0000) begin
            q <= c_lfsr_seed;
        end else begin
            q <= {q[14:0], w_feedback};
        end
    end

endmodule
`default_nettype wire

// File: rtl/arrow_spawner.sv
`default_nettype none
// ============================================================================
//  Module   : arrow_spawner
//  Purpose  : Game FSM launching arrows, resolving block/hit, tracking score.
//  Revision : 1.0  initial release
// ============================================================================
module arrow_spawner
    import game_pkg::*;
#(
    parameter int LIVES_INIT    = 3,
    parameter int GAP_FRAMES    = 30,
    parameter int FLIGHT_FRAMES = 120,
    parameter int INVERT_EN     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        start_in,
    input  logic [1:0]  shield_dir_in,
    input  logic        hit_in,
    output logic        arrow_valid,
    output logic [1:0]  arrow_direction,
    output logic [2:0]  arrow_speed,
    output logic        arrow_inversed,
    output logic [7:0]  score,
    output logic [2:0]  lives,
    output logic        game_over
);

    localparam logic [2:0]  c_lives_init    = 3'(LIVES_INIT);
    localparam logic [15:0] c_gap_frames    = 16'(GAP_FRAMES);
    localparam logic [15:0] c_flight_frames = 16'(FLIGHT_FRAMES);
    localparam logic        c_invert_en     = (INVERT_EN != 0);

    state_t      r_state;
    logic [15:0] r_count;
    logic        r_hit_q;
    dir_t        r_dir;
    logic        r_inv;
    logic [7:0]  r_score;
    logic [2:0]  r_lives;

    logic [15:0] w_lfsr;
    logic        w_unused_lfsr;
    logic        w_frame_tick;
    logic        w_hit_rise;
    logic [15:0] w_speed_x2;
    logic [15:0] w_gap_len;
    logic        w_blocked;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (w_lfsr)
    );

    assign w_unused_lfsr = ^w_lfsr[15:3];

    assign w_frame_tick = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign w_hit_rise   = hit_in && !r_hit_q;

    assign arrow_speed = (r_score[7:6] != 2'b00) ? 3'd7 : r_score[5:3];

    // Gap shrinks by two frames per speed level, floored at two frames.
    assign w_speed_x2 = {12'd0, arrow_speed, 1'b0};
    assign w_gap_len  = (c_gap_frames >= w_speed_x2 + 16'd2) ? (c_gap_frames - w_speed_x2) : 16'd2;

    assign w_blocked = (shield_dir_in == required_side(r_dir, r_inv));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_count <= 16'd0;
            r_hit_q <= 1'b0;
            r_dir   <= DIR_TOP;
            r_inv   <= 1'b0;
            r_score <= 8'd0;
            r_lives <= c_lives_init;
        end else begin
            r_hit_q <= hit_in;
            case (r_state)
                c_st_idle, c_st_over: begin
                    if (start_in) begin
                        r_state <= c_st_gap;
                        r_score <= 8'd0;
                        r_lives <= c_lives_init;
                        r_count <= 16'd0;
                    end
                end
                c_st_gap: begin
                    if (r_count >= w_gap_len) begin
                        r_state <= c_st_flight;
                        r_count <= 16'd0;
                        r_dir   <= dir_t'(w_lfsr[1:0]);
                        r_inv   <= w_lfsr[2] & c_invert_en;
                    end else if (w_frame_tick) begin
                        r_count <= r_count + 16'd1;
                    end
                end
                c_st_flight: begin
                    // A hit edge takes priority over a coincident frame tick.
                    if (w_hit_rise || (r_count >= c_flight_frames)) begin
                        r_state <= c_st_resolve;
                    end else if (w_frame_tick) begin
                        r_count <= r_count + 16'd1;
                    end
                end
                c_st_resolve: begin
                    r_count <= 16'd0;
                    if (w_blocked) begin
                        r_state <= c_st_gap;
                        if (r_score != 8'hFF) begin
                            r_score <= r_score + 8'd1;
                        end
                    end else begin
                        if (r_lives != 3'd0) begin
                            r_lives <= r_lives - 3'd1;
                        end
                        r_state <= (r_lives == 3'd1) ? c_st_over : c_st_gap;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign arrow_valid     = (r_state == c_st_flight);
    assign game_over       = (r_state == c_st_over);
    assign arrow_direction = r_dir;
    assign arrow_inversed  = r_inv;
    assign score           = r_score;
    assign lives           = r_lives;

endmodule
`default_nettype wire

// File: tb/tb_arrow_spawner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arrow_spawner
//  Purpose  : Directed self-checking bench for arrow_spawner.
//  Revision : 1.0  initial release
// ============================================================================
module tb_arrow_spawner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        start_in;
    logic [1:0]  shield_dir_in;
    logic        hit_in;
    logic        arrow_valid;
    logic [1:0]  arrow_direction;
    logic [2:0]  arrow_speed;
    logic        arrow_inversed;
    logic [7:0]  score;
    logic [2:0]  lives;
    logic        game_over;

    always #5 clk = ~clk;

    arrow_spawner #(
        .LIVES_INIT    (3),
        .GAP_FRAMES    (30),
        .FLIGHT_FRAMES (120),
        .INVERT_EN     (1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hcount_in       (hcount_in),
        .vcount_in       (vcount_in),
        .start_in        (start_in),
        .shield_dir_in   (shield_dir_in),
        .hit_in          (hit_in),
        .arrow_valid     (arrow_valid),
        .arrow_direction (arrow_direction),
        .arrow_speed     (arrow_speed),
        .arrow_inversed  (arrow_inversed),
        .score           (score),
        .lives           (lives),
        .game_over       (game_over)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int m_score;
    int m_lives;
    logic [15:0] m_lfsr;
    logic [15:0] m_prev;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Reference LFSR; m_prev holds the value the DUT saw before the latest edge.
    always @(posedge clk) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= lfsr_next(m_lfsr);
        m_prev <= m_lfsr;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        hcount_in = 11'd0;
        vcount_in = 10'd0;
        step();
        hcount_in = 11'd7;
        vcount_in = 10'd3;
        step();
    endtask

    task automatic fake_tick();
        hcount_in = 11'd0;
        vcount_in = 10'd1;
        step();
        hcount_in = 11'd1;
        vcount_in = 10'd0;
        step();
        hcount_in = 11'd7;
        vcount_in = 10'd3;
    endtask

    task automatic run_gap(input int len);
        logic early;
        early = 1'b0;
        for (int i = 0; i < len; i++) begin
            tick();
            if (i < len - 1 && arrow_valid) early = 1'b1;
        end
        check("gap_early_launch", early, 0);
        check("gap_launch", arrow_valid, 1);
    endtask

    // mode: 0 block+hit, 1 unblock+hit, 2 raw shield=dir with hit on a frame tick, 3 unblock+timeout
    task automatic do_arrow(input int mode);
        int spd;
        int gap;
        logic [1:0] edir;
        logic [1:0] req;
        logic [1:0] shld;
        logic einv;
        spd = ((m_score >> 3) > 7) ? 7 : (m_score >> 3);
        check("speed", arrow_speed, spd);
        gap = 30 - 2 * spd;
        if (gap < 2) gap = 2;
        if (mode == 3) hit_in = 1'b1;
        run_gap(gap);
        edir = m_prev[1:0];
        einv = m_prev[2];
        check("direction", arrow_direction, edir);
        check("inversed", arrow_inversed, einv);
        req = einv ? (edir ^ 2'b01) : edir;
        case (mode)
            0:       shld = req;
            2:       shld = edir;
            default: shld = req ^ 2'b10;
        endcase
        shield_dir_in = shld;
        if (mode == 3) begin
            for (int i = 0; i < 119; i++) tick();
            check("flight_hold", arrow_valid, 1);
            tick();
            check("timeout_exit", arrow_valid, 0);
        end else begin
            hit_in = 1'b1;
            if (mode == 2) begin
                hcount_in = 11'd0;
                vcount_in = 10'd0;
            end
            step();
            hcount_in = 11'd7;
            vcount_in = 10'd3;
            check("hit_exit", arrow_valid, 0);
        end
        step();
        if (shld == req) begin
            if (m_score < 255) m_score++;
        end else if (m_lives > 0) begin
            m_lives--;
        end
        check("score", score, m_score);
        check("lives", lives, m_lives);
        check("game_over", game_over, (m_lives == 0) ? 1 : 0);
        check("valid_after_resolve", arrow_valid, 0);
        hit_in = 1'b0;
    endtask

    initial begin
        logic seen;
        int guard;
        rst_n = 1'b0;
        start_in = 1'b0;
        hcount_in = 11'd7;
        vcount_in = 10'd3;
        shield_dir_in = 2'b00;
        hit_in = 1'b0;
        m_score = 0;
        m_lives = 3;
        step();
        step();
        check("rst_valid", arrow_valid, 0);
        check("rst_dir", arrow_direction, 0);
        check("rst_inv", arrow_inversed, 0);
        check("rst_score", score, 0);
        check("rst_lives", lives, 3);
        check("rst_over", game_over, 0);
        check("rst_speed", arrow_speed, 0);

        rst_n = 1'b1;
        tick();
        check("idle_no_launch", arrow_valid, 0);
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        check("start_lives", lives, 3);
        check("start_score", score, 0);

        // Row/column zero alone must not count as a frame tick.
        for (int i = 0; i < 5; i++) fake_tick();
        do_arrow(0);
        do_arrow(2);
        do_arrow(3);
        guard = 0;
        while (m_lives > 0 && guard < 6) begin
            do_arrow(1);
            guard++;
        end

        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (arrow_valid) seen = 1'b1;
        end
        check("over_no_launch", seen, 0);
        check("over_flag", game_over, 1);
        check("over_lives", lives, 0);
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        m_score = 0;
        m_lives = 3;
        check("restart_lives", lives, 3);
        check("restart_score", score, 0);
        check("restart_over", game_over, 0);

        while (m_score < 56) do_arrow(0);
        check("speed_at_56", arrow_speed, 7);
        while (m_score < 255) do_arrow(0);
        do_arrow(0);
        check("score_saturate", score, 255);

        // Reset while an arrow is in flight.
        run_gap(16);
        rst_n = 1'b0;
        step();
        check("midflight_rst_valid", arrow_valid, 0);
        check("midflight_rst_lives", lives, 3);
        check("midflight_rst_score", score, 0);
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
